// File: rtl/desc_loader_db.sv
// ---------------------------------------------------------------------------
// desc_loader_db
//
// Double-buffered descriptor loader for the NCC PE array. Packed unsigned
// pixels arrive over a valid/ready stream. Each pixel is converted to the
// 33-bit log2 format {sign, int[4:0], frac[26:0]} and written row-major into
// the shadow bank. When the last word has landed, the shadow bank becomes the
// active bank in a single edge. The PE grid therefore keeps correlating
// against the previous descriptor while the next one streams in.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-high
//   start        begin a new load (honoured only in IDLE, and not with abort)
//   abort        cancel an in-progress load; the active bank is untouched
//   in_valid     in_data valid
//   in_ready     loader accepts a word this cycle
//   in_data      PPW packed pixels; the MS pixel is the lowest column
//   busy         loader is not idle
//   load_done    one-cycle pulse in the cycle after the bank swap
//   desc_valid   active bank holds a completed descriptor (sticky)
//   active_bank  index of the bank driving desc_out
//   desc_out     active bank; pixel (r,c) at [33*(r*DIM+c) +: 33]
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; in_ready low
// LOAD   | accepting words; row/group counters advance on each accept
// FLUSH  | last word is in stage 1; it is written as the banks swap
// ---------------------------------------------------------------------------
module desc_loader_db #(
    parameter int DIM   = 16,
    parameter int PIX_W = 8,
    parameter int PPW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W*PPW-1:0]  in_data,
    output logic                  busy,
    output logic                  load_done,
    output logic                  desc_valid,
    output logic                  active_bank,
    output logic [DIM*DIM*33-1:0] desc_out
);

    localparam int WPR   = DIM / PPW;
    localparam int NPIX  = DIM * DIM;
    localparam int ROW_W = $clog2(DIM);
    localparam int GRP_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PA_W  = $clog2(NPIX);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(WPR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             last_word;
    logic             ctr_clear;
    logic             swap;

    logic [ROW_W-1:0] row;
    logic [GRP_W-1:0] grp;

    logic                 s1_valid;
    logic [ROW_W-1:0]     s1_row;
    logic [GRP_W-1:0]     s1_grp;
    logic [PIX_W*PPW-1:0] s1_data;

    logic                 wr_en;
    logic [32:0]          pix_log [PPW];

    logic [32:0] bank0 [NPIX];
    logic [32:0] bank1 [NPIX];

    // Leading-one index n goes in the integer field. The bits below the
    // leading one are left-aligned into the 27-bit fraction: shifting
    // {x, 27'b0} right by n drops bit n of x onto bit 27, leaving the lower
    // bits at 26:0. Inputs 0 and 1 both give n=0 with an empty fraction.
    function automatic logic [32:0] log2_fmt(input logic [31:0] x);
        logic [4:0]  n;
        logic [58:0] shifted;
        n = 5'd0;
        for (int i = 1; i < 32; i++) begin
            if (x[i]) n = 5'(i);
        end
        shifted = {x, 27'd0} >> n;
        return {x[31], n, shifted[26:0]};
    endfunction

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    assign last_word = (row == ROW_LAST) && (grp == GRP_LAST);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ctr_clear = 1'b0;
        swap      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_LOAD;
                    ctr_clear = 1'b1;
                end
            end
            S_LOAD: begin
                in_ready = !abort;
                if (abort)                       state_nxt = S_IDLE;
                else if (in_valid && last_word)  state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                state_nxt = S_IDLE;
                swap      = !abort;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // Row / column-group address counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            grp <= '0;
        end else if (ctr_clear || abort) begin
            row <= '0;
            grp <= '0;
        end else if (accept) begin
            if (grp == GRP_LAST) begin
                grp <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                grp <= grp + GRP_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 1: capture the accepted word with its address. in_ready is
    // already low under abort, so an abort also empties this stage.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_grp   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_row  <= row;
                s1_grp  <= grp;
                s1_data <= in_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: log2 conversion and shadow-bank write
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < PPW; k++) begin
            pix_log[k] = log2_fmt(32'(s1_data[(PPW-1-k)*PIX_W +: PIX_W]));
        end
    end

    // The word still in flight when abort arrives is dropped.
    assign wr_en = s1_valid & !abort;

    // The shadow bank is always !active_bank as seen before this edge. The
    // final write of a load and the swap therefore hit the same edge, and
    // the newly active bank is complete from its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPIX; p++) begin
                bank0[p] <= '0;
                bank1[p] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < PPW; k++) begin
                if (active_bank)
                    bank0[PA_W'(int'(s1_row)*DIM + int'(s1_grp)*PPW + k)] <= pix_log[k];
                else
                    bank1[PA_W'(int'(s1_row)*DIM + int'(s1_grp)*PPW + k)] <= pix_log[k];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Swap bookkeeping
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank <= 1'b0;
            desc_valid  <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= swap;
            if (swap) begin
                active_bank <= ~active_bank;
                desc_valid  <= 1'b1;
            end
        end
    end

    // desc_out is a pure mux of registered banks.
    for (genvar p = 0; p < NPIX; p++) begin : g_out
        assign desc_out[33*p +: 33] = active_bank ? bank1[p] : bank0[p];
    end

endmodule

// File: tb/tb_desc_loader_db.sv
module tb_desc_loader_db;

    localparam int DIM   = 16;
    localparam int PIX_W = 8;
    localparam int PPW   = 4;
    localparam int WPR   = DIM / PPW;
    localparam int NW    = DIM * WPR;
    localparam int NPIX  = DIM * DIM;
    localparam int DW    = PIX_W * PPW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic                 busy;
    logic                 load_done;
    logic                 desc_valid;
    logic                 active_bank;
    logic [NPIX*33-1:0]   desc_out;

    int checks   = 0;
    int failures = 0;
    int hold_bad;

    logic [32:0]   exp_desc  [NPIX];
    logic [32:0]   pend_desc [NPIX];
    logic          exp_bank;
    logic          exp_valid;
    logic [DW-1:0] words [NW];

    desc_loader_db #(.DIM(DIM), .PIX_W(PIX_W), .PPW(PPW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .load_done   (load_done),
        .desc_valid  (desc_valid),
        .active_bank (active_bank),
        .desc_out    (desc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference log2: floor(log2 x) in the integer field, remainder above
    // the power of two scaled to a 27-bit binary fraction.
    function automatic logic [32:0] ref_log2(input longint unsigned x);
        longint unsigned n, p, frac;
        if (x < 2) return 33'd0;
        n = 0;
        p = 1;
        while (p * 2 <= x) begin
            p = p * 2;
            n++;
        end
        frac = ((x - p) * 64'd134217728) / p;
        return 33'((n * 64'd134217728) + frac);
    endfunction

    function automatic int first_diff(input logic [NPIX*33-1:0] d, input logic [32:0] e [NPIX]);
        for (int p = 0; p < NPIX; p++) begin
            if (d[33*p +: 33] !== e[p]) return p;
        end
        return -1;
    endfunction

    task automatic build_expected();
        int r, c;
        longint unsigned v;
        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < PPW; k++) begin
                r = i / WPR;
                c = (i % WPR) * PPW + k;
                v = longint'((words[i] >> (PIX_W * (PPW - 1 - k))) & 32'hFF);
                pend_desc[r*DIM + c] = ref_log2(v);
            end
        end
    endtask

    task automatic fill_pattern();
        logic [7:0] b;
        for (int i = 0; i < NW; i++) begin
            b = 8'(i);
            words[i] = {b, b, b, b};
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) words[i] = $urandom();
    endtask

    // Feed words[first .. first+count-1] following the handshake. Every cycle,
    // check that the active descriptor is unchanged and that no swap occurred.
    task automatic feed(input int first, input int count, input bit gaps,
                        input int start_at, inout int cyc, output bit ok);
        int idx, guard;
        bit acc;
        idx   = first;
        guard = 0;
        while (idx < first + count && guard < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = words[idx];
            start    = (idx == start_at);
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            guard++;
            if (acc) idx++;
            if (first_diff(desc_out, exp_desc) != -1) hold_bad++;
            if (load_done) hold_bad++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        ok = (idx == first + count);
    endtask

    task automatic wait_done(inout int cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (load_done) got = 1'b1;
        end
    endtask

    task automatic run_load(input string tag, input bit gaps, input int start_at);
        int cyc, d;
        bit ok, got;
        build_expected();
        hold_bad = 0;
        cyc      = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        feed(0, NW, gaps, start_at, cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s feed_stalled: got stall want %0d words accepted", tag, NW);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s flush_state: got in_ready=%b busy=%b want 0 1", tag, in_ready, busy);
        end
        wait_done(cyc, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s load_done_missing: got none want pulse", tag);
        end
        if (!gaps) begin
            checks++;
            if (cyc !== NW + 1) begin
                failures++;
                $display("FAIL %s done_latency: got %0d want %0d edges after start", tag, cyc, NW + 1);
            end
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL %s hold_before_swap: got %0d bad cycles want 0", tag, hold_bad);
        end
        for (int p = 0; p < NPIX; p++) exp_desc[p] = pend_desc[p];
        exp_bank  = ~exp_bank;
        exp_valid = 1'b1;
        d = first_diff(desc_out, exp_desc);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL %s desc_pixel_%0d: got %h want %h", tag, d, desc_out[33*d +: 33], exp_desc[d]);
        end
        checks++;
        if (active_bank !== exp_bank || desc_valid !== exp_valid || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s post_swap_flags: got bank=%b valid=%b busy=%b want %b %b 0",
                     tag, active_bank, desc_valid, busy, exp_bank, exp_valid);
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s in_ready_idle: got %b want 0", tag, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL %s load_done_width: got %b want 0", tag, load_done);
        end
    endtask

    task automatic check_idle_unchanged(input string tag);
        int d;
        d = first_diff(desc_out, exp_desc);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL %s desc_changed_pixel_%0d: got %h want %h", tag, d, desc_out[33*d +: 33], exp_desc[d]);
        end
        checks++;
        if (active_bank !== exp_bank || desc_valid !== exp_valid || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s flags: got bank=%b valid=%b busy=%b want %b %b 0",
                     tag, active_bank, desc_valid, busy, exp_bank, exp_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 ||
            desc_valid !== 1'b0 || active_bank !== 1'b0 || desc_out !== '0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b busy=%b done=%b valid=%b bank=%b out_nz=%b want all 0",
                     in_ready, busy, load_done, desc_valid, active_bank, |desc_out);
        end
    endtask

    task automatic test_full_load();
        fill_pattern();
        run_load("full", 1'b0, -1);
        checks++;
        if (desc_out[33*(1*DIM+0) +: 33] !== 33'h0_1000_0000) begin
            failures++;
            $display("FAIL full_pix_1_0: got %h want %h", desc_out[33*(1*DIM+0) +: 33], 33'h0_1000_0000);
        end
        checks++;
        if (desc_out[33*(15*DIM+15) +: 33] !== 33'h0_2FC0_0000) begin
            failures++;
            $display("FAIL full_pix_15_15: got %h want %h", desc_out[33*(15*DIM+15) +: 33], 33'h0_2FC0_0000);
        end
        checks++;
        if (active_bank !== 1'b1) begin
            failures++;
            $display("FAIL full_active_bank: got %b want 1", active_bank);
        end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        bit ok;
        fill_random();
        cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(0, 10, 1'b0, -1, cyc, ok);
        in_valid = 1'b1;
        rst = 1'b1;
        #2;
        for (int p = 0; p < NPIX; p++) exp_desc[p] = 33'd0;
        exp_bank  = 1'b0;
        exp_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 ||
            desc_valid !== 1'b0 || active_bank !== 1'b0 || desc_out !== '0) begin
            failures++;
            $display("FAIL rst_mid_load: got rdy=%b busy=%b done=%b valid=%b bank=%b out_nz=%b want all 0",
                     in_ready, busy, load_done, desc_valid, active_bank, |desc_out);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_unchanged("rst_release");
    endtask

    task automatic test_log2_word();
        logic [32:0] want [4];
        want[0] = 33'h0_3800_0000;
        want[1] = 33'h0_3FF0_0000;
        want[2] = 33'h0_0C00_0000;
        want[3] = 33'h0_0000_0000;
        fill_random();
        words[0] = 32'h80FF_0300;
        run_load("log2", 1'b0, -1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (desc_out[33*c +: 33] !== want[c]) begin
                failures++;
                $display("FAIL log2_pix_0_%0d: got %h want %h", c, desc_out[33*c +: 33], want[c]);
            end
        end
    endtask

    task automatic test_second_load();
        fill_random();
        run_load("second", 1'b0, -1);
        checks++;
        if (active_bank !== 1'b0) begin
            failures++;
            $display("FAIL second_active_bank: got %b want 0", active_bank);
        end
    endtask

    task automatic test_gaps();
        fill_pattern();
        run_load("gaps", 1'b1, -1);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_load("start_in_load", 1'b0, 20);
    endtask

    task automatic test_abort_mid();
        int cyc, dones;
        bit ok;
        fill_random();
        hold_bad = 0;
        cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(0, 37, 1'b1, -1, cyc, ok);
        abort = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid_busy: got %b want 0", busy);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (load_done) dones++;
        end
        in_valid = 1'b0;
        checks++;
        if (dones !== 0 || hold_bad !== 0 || !ok) begin
            failures++;
            $display("FAIL abort_mid_no_done: got dones=%0d hold_bad=%0d fed=%b want 0 0 1", dones, hold_bad, ok);
        end
        check_idle_unchanged("abort_mid");
    endtask

    task automatic test_abort_flush();
        int cyc, dones;
        bit ok;
        fill_random();
        hold_bad = 0;
        cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(0, NW, 1'b0, -1, cyc, ok);
        checks++;
        if (busy !== 1'b1 || !ok) begin
            failures++;
            $display("FAIL abort_flush_setup: got busy=%b fed=%b want 1 1", busy, ok);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        dones = load_done ? 1 : 0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_flush_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (load_done) dones++;
        end
        checks++;
        if (dones !== 0 || hold_bad !== 0) begin
            failures++;
            $display("FAIL abort_flush_no_done: got dones=%0d hold_bad=%0d want 0 0", dones, hold_bad);
        end
        check_idle_unchanged("abort_flush");
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reload_after_abort();
        fill_random();
        run_load("reload", 1'b1, -1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_bank  = 1'b0;
        exp_valid = 1'b0;
        for (int p = 0; p < NPIX; p++) exp_desc[p] = 33'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_full_load();
        test_reset_mid_load();
        test_log2_word();
        test_second_load();
        test_gaps();
        test_start_ignored();
        test_abort_mid();
        test_abort_flush();
        test_start_abort_idle();
        test_reload_after_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
